// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - FSM state type and COMPUTE-length helper for the systolic multiplier
package systolic_pkg;
  typedef enum logic [1:0] {ST_LOAD, ST_COMPUTE, ST_DRAIN} state_t;

  function automatic int compute_len(input int n);
    return 3 * n - 2;
  endfunction
endpackage

// File: rtl/systolic_pe.sv
// rtl/systolic_pe.sv - one multiply-accumulate cell with registered east/south pass-through
// SYSTOLIC_SAT_EN selects saturating accumulation; otherwise the accumulator wraps.
module systolic_pe #(
  parameter int DW   = 8,
  parameter int ACCW = 2 * DW
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            en,
  input  logic [DW-1:0]   a_west,
  input  logic [DW-1:0]   b_north,
  output logic [DW-1:0]   a_east,
  output logic [DW-1:0]   b_south,
  output logic [ACCW-1:0] acc
);
  localparam int SW = ACCW + 2 * DW;

  logic [2*DW-1:0] prod;
  logic [ACCW-1:0] acc_next;

  assign prod = {{DW{1'b0}}, a_west} * {{DW{1'b0}}, b_north};

`ifdef SYSTOLIC_SAT_EN
  logic [SW:0] sum;
  assign sum      = (SW + 1)'(acc) + (SW + 1)'(prod);
  assign acc_next = (sum > (SW + 1)'({ACCW{1'b1}})) ? {ACCW{1'b1}} : sum[ACCW-1:0];
`else
  assign acc_next = ACCW'({{(2*DW){1'b0}}, acc} + {{ACCW{1'b0}}, prod});
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_east  <= '0;
      b_south <= '0;
      acc     <= '0;
    end else if (clr) begin
      a_east  <= '0;
      b_south <= '0;
      acc     <= '0;
    end else if (en) begin
      a_east  <= a_west;
      b_south <= b_north;
      acc     <= acc_next;
    end
  end
endmodule

// File: rtl/systolic_matmul_axis.sv
// rtl/systolic_matmul_axis.sv - NxN output-stationary systolic matrix multiplier with stream handshakes
// Optional SYSTOLIC_SAT_EN makes the PE accumulators saturate instead of wrap.
module systolic_matmul_axis
  import systolic_pkg::*;
#(
  parameter int N    = 3,
  parameter int DW   = 8,
  parameter int ACCW = 2 * DW
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst_n,
  input  logic                  s_axis_valid,
  input  logic [2*N*DW-1:0]     s_axis_data,
  output logic                  s_axis_ready,
  output logic                  m_axis_valid,
  output logic [N*N*ACCW-1:0]   m_axis_data,
  input  logic                  m_axis_ready,
  output logic                  busy
);
  localparam int CL = compute_len(N);
  localparam int BW = $clog2(N);
  localparam int CW = $clog2(CL);

  state_t        state;
  logic [BW-1:0] bcnt;
  logic [CW-1:0] ccnt;
  logic [DW-1:0] a_buf [N][N];  // [beat][row of A]
  logic [DW-1:0] b_buf [N][N];  // [beat][column of B]
  logic [DW-1:0] a_inj [N];
  logic [DW-1:0] b_inj [N];
  logic [DW-1:0] a_h   [N][N+1];
  logic [DW-1:0] b_v   [N+1][N];
  logic          take, clr, en, unused_edge;

  assign take = (state == ST_LOAD) && s_axis_valid && s_axis_ready;
  assign clr  = take && (bcnt == BW'(N - 1));
  assign en   = (state == ST_COMPUTE);

  always_ff @(posedge axi_clk or negedge axi_rst_n) begin
    if (!axi_rst_n) begin
      state        <= ST_LOAD;
      bcnt         <= '0;
      ccnt         <= '0;
      s_axis_ready <= 1'b0;
      m_axis_valid <= 1'b0;
      busy         <= 1'b0;
      for (int k = 0; k < N; k++)
        for (int e = 0; e < N; e++) begin
          a_buf[k][e] <= '0;
          b_buf[k][e] <= '0;
        end
    end else begin
      case (state)
        ST_LOAD: begin
          s_axis_ready <= 1'b1;
          if (take) begin
            for (int k = 0; k < N; k++)
              if (bcnt == BW'(k))
                for (int e = 0; e < N; e++) begin
                  a_buf[k][e] <= s_axis_data[e*DW +: DW];
                  b_buf[k][e] <= s_axis_data[N*DW + e*DW +: DW];
                end
            if (bcnt == BW'(N - 1)) begin
              bcnt         <= '0;
              ccnt         <= '0;
              state        <= ST_COMPUTE;
              s_axis_ready <= 1'b0;
              busy         <= 1'b1;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end
        end
        ST_COMPUTE: begin
          if (ccnt == CW'(CL - 1)) begin
            state        <= ST_DRAIN;
            m_axis_valid <= 1'b1;
          end else begin
            ccnt <= ccnt + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (m_axis_ready) begin
            state        <= ST_LOAD;
            m_axis_valid <= 1'b0;
            busy         <= 1'b0;
            s_axis_ready <= 1'b1;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Row i / column j enter i / j cycles late; element k reaches the edge at step i+k (j+k).
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_inj[i] = '0;
      b_inj[i] = '0;
      for (int k = 0; k < N; k++)
        if (en && (int'(ccnt) == i + k)) begin
          a_inj[i] = a_buf[k][i];
          b_inj[i] = b_buf[k][i];
        end
    end
  end

  always_comb begin
    unused_edge = 1'b0;
    for (int i = 0; i < N; i++)
      unused_edge = unused_edge ^ (^a_h[i][N]) ^ (^b_v[N][i]);
  end

  for (genvar i = 0; i < N; i++) begin : g_edge
    assign a_h[i][0] = a_inj[i];
    assign b_v[0][i] = b_inj[i];
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      systolic_pe #(.DW(DW), .ACCW(ACCW)) u_pe (
        .clk    (axi_clk),
        .rst_n  (axi_rst_n),
        .clr    (clr),
        .en     (en),
        .a_west (a_h[i][j]),
        .b_north(b_v[i][j]),
        .a_east (a_h[i][j+1]),
        .b_south(b_v[i+1][j]),
        .acc    (m_axis_data[(i*N+j)*ACCW +: ACCW])
      );
    end
  end
endmodule

// File: doc/systolic_matmul_axis.md
SYSTOLIC_MATMUL_AXIS -- requirements
Module: systolic_matmul_axis

Interface
REQ-001 The block SHALL have parameter N, default 3, meaning the array dimension (NxN processing elements, N >= 2).
REQ-002 The block SHALL have parameter DW, default 8, meaning the unsigned operand element width in bits.
REQ-003 The block SHALL have parameter ACCW, default 2*DW, meaning the accumulator and result element width in bits.
REQ-004 The block SHALL have the port axi_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have the port axi_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have the port s_axis_valid, input, 1 bit: the input beat is valid.
REQ-007 The block SHALL have the port s_axis_data, input, 2*N*DW bits: bits [N*DW-1:0] carry A column k (element i at [i*DW +: DW]); the upper N*DW bits carry B row k (element j at [N*DW + j*DW +: DW]).
REQ-008 The block SHALL have the port s_axis_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009 The block SHALL have the port m_axis_valid, output, 1 bit: the result is valid.
REQ-010 The block SHALL have the port m_axis_data, output, N*N*ACCW bits: C[i][j] at [(i*N+j)*ACCW +: ACCW].
REQ-011 The block SHALL have the port m_axis_ready, input, 1 bit: downstream accepts the result.
REQ-012 The block SHALL have the port busy, output, 1 bit: high in COMPUTE or DRAIN.

Function
REQ-013 The block SHALL compute C = A x B, where beat k (k = 0..N-1, in acceptance order) supplies A[*][k] and B[k][*].
REQ-014 The block SHALL use FSM states LOAD, COMPUTE and DRAIN; the reset state is LOAD.
REQ-015 In LOAD, s_axis_ready SHALL equal 1; a beat SHALL be accepted only when s_axis_valid and s_axis_ready are both 1; gaps in valid stall loading without loss.
REQ-016 On acceptance of the N-th beat, the FSM SHALL go to COMPUTE on the next cycle, and s_axis_ready SHALL be 0 from that cycle until return to LOAD.
REQ-017 COMPUTE SHALL last exactly 3N-2 cycles; row i of A and column j of B SHALL be skewed by i and j cycles respectively, with zeros injected outside the valid window.
REQ-018 Each PE SHALL perform acc <= acc + a*b per cycle, with the product computed at full 2*DW width and the accumulation truncated or saturated to ACCW per REQ-024/REQ-025.
REQ-019 After COMPUTE, the FSM SHALL enter DRAIN, and m_axis_valid SHALL be 1 exactly 3N-1 cycles after the cycle in which the N-th beat was accepted.
REQ-020 In DRAIN, m_axis_valid and m_axis_data SHALL hold stable until m_axis_ready is 1; on that handshake the FSM SHALL return to LOAD, and m_axis_valid SHALL fall on the next cycle.
REQ-021 All accumulators SHALL clear to 0 on the LOAD-to-COMPUTE transition, so no state carries over between matrices.
REQ-022 A beat presented with s_axis_valid=1 during COMPUTE or DRAIN SHALL NOT be accepted and SHALL NOT alter state.

Reset
REQ-023 On assertion of axi_rst_n=0, at any state including mid-COMPUTE or mid-DRAIN, the block SHALL immediately clear the FSM to LOAD, the beat counter, the skew registers and the accumulators, and SHALL drive s_axis_ready=0, m_axis_valid=0, m_axis_data=0 and busy=0; s_axis_ready SHALL rise on the first clock edge after release.

Configuration
REQ-024 With macro SYSTOLIC_SAT_EN defined, accumulation SHALL saturate at 2^ACCW-1 and stay there for the rest of the matrix.
REQ-025 Without SYSTOLIC_SAT_EN, accumulation SHALL wrap modulo 2^ACCW.

Structure
REQ-026 Package systolic_pkg SHALL hold the FSM state enum and a function computing the COMPUTE length (3N-2).
REQ-027 The PE SHALL be a separate sub-module systolic_pe (registered a/b pass-through east/south, accumulator, clear input), instantiated NxN by generate loops.
REQ-028 The counter widths SHALL be derived using $clog2 from N.

Verification
REQ-029 The bench SHALL cover: N=3, DW=8, with A = identity and B = [1..9] row-major -> m_axis_data C equals B, m_axis_valid rising 8 cycles after the 3rd beat.
REQ-030 The bench SHALL cover: all elements 255, without SYSTOLIC_SAT_EN -> every C element equals 64003 (195075 mod 65536); with SYSTOLIC_SAT_EN -> every C element equals 65535.
REQ-031 The bench SHALL cover: m_axis_ready held 0 for 10 cycles in DRAIN -> data stable, s_axis_ready=0 throughout, return to LOAD one cycle after ready.
REQ-032 The bench SHALL cover: s_axis_valid toggled 1-0-1-0-1 -> exactly 3 beats accepted and the correct product produced.
REQ-033 The bench SHALL cover: axi_rst_n pulsed low at COMPUTE cycle 3 -> outputs zero immediately; a following matrix computes correctly with no residue.
REQ-034 The bench SHALL cover: back-to-back matrices with m_axis_ready=1 -> the second result is independent of the first, and a beat offered in DRAIN is not accepted.
